r200_dmem_ctrl: RTL and testbench

//  Data-memory bus controller downstream of the r200 MEM stage. Takes one load/store per

---
 rtl/r200_dmem_bus_if.sv | 34 +++
 rtl/r200_dmem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_r200_dmem_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/r200_dmem_bus_if.sv
// r200 data-memory bus: req/gnt address phase plus rvalid response phase.
// master = controller side, slave = memory side.
interface r200_dmem_bus_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_gnt,
        input  bus_rvalid,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_gnt,
        output bus_rvalid,
        output bus_rdata
    );
endinterface

// File: rtl/r200_dmem_ctrl.sv
// r200 data-memory controller: one load/store per instruction over req/gnt/rvalid,
// byte-lane store replication, load extension, timeout abort.
module r200_dmem_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        misalign,
    output logic        bus_err,
    r200_dmem_bus_if.master bus
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP,
        DONE
    } state_e;

    state_e      state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        is_ld_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] ld_data_q;
    logic        ld_valid_q;
    logic        bus_err_q;

    logic        legal;
    logic        aligned;
    logic        ok;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] lane;
    logic [31:0] ext_d;

    // Request decode: width/sign legality, alignment, lane mapping.
    always_comb begin
        legal   = 1'b0;
        aligned = 1'b0;
        be_d    = 4'b0000;
        wdata_d = 32'h0;
        case (req_func3)
            3'b000, 3'b100: begin
                legal   = !req_we || !req_func3[2];
                aligned = 1'b1;
                be_d    = 4'b0001 << req_addr[1:0];
                wdata_d = {4{req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                legal   = !req_we || !req_func3[2];
                aligned = !req_addr[0];
                be_d    = 4'b0011 << req_addr[1:0];
                wdata_d = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                legal   = 1'b1;
                aligned = (req_addr[1:0] == 2'b00);
                be_d    = 4'b1111;
                wdata_d = req_wdata;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        ok = legal && aligned;
    end

    // Response lane select and extension, using the launched width/offset.
    always_comb begin
        lane  = bus.bus_rdata >> {off_q, 3'b000};
        ext_d = lane;
        case (f3_q[1:0])
            2'b00:   ext_d = {{24{lane[7] & ~f3_q[2]}}, lane[7:0]};
            2'b01:   ext_d = {{16{lane[15] & ~f3_q[2]}}, lane[15:0]};
            default: ext_d = lane;
        endcase
    end

    assign stall = rst && (((state_q == IDLE) && req_valid && ok)
                           || (state_q == ADDR) || (state_q == RESP));
    assign misalign = rst && (state_q == IDLE) && req_valid && !ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            is_ld_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
            ld_data_q   <= 32'h0;
            ld_valid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            ld_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid && ok) begin
                        state_q     <= ADDR;
                        cnt_q       <= '0;
                        f3_q        <= req_func3;
                        off_q       <= req_addr[1:0];
                        is_ld_q     <= !req_we;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= req_we;
                        bus_addr_q  <= {req_addr[31:2], 2'b00};
                        bus_be_q    <= be_d;
                        bus_wdata_q <= wdata_d;
                    end
                end
                ADDR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q   <= DONE;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        bus_err_q <= 1'b1;
                        ld_data_q <= 32'h0;
                    end else if (bus.bus_gnt) begin
                        state_q   <= RESP;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                    end
                end
                RESP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.bus_rvalid) begin
                        state_q <= DONE;
                        if (is_ld_q) begin
                            ld_data_q  <= ext_d;
                            ld_valid_q <= 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= DONE;
                        bus_err_q <= 1'b1;
                        ld_data_q <= 32'h0;
                    end
                end
                // Same instruction is still presented here; never relaunch.
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign ld_data       = ld_data_q;
    assign ld_valid      = ld_valid_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_r200_dmem_ctrl.sv
// Bench for r200_dmem_ctrl: timeline model per transaction, randomized
// requests and bus latencies, directed corner cases.
module tb_r200_dmem_ctrl;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        misalign;
    logic        bus_err;

    r200_dmem_bus_if bus ();

    r200_dmem_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .ld_data   (ld_data),
        .ld_valid  (ld_valid),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    logic [31:0] exp_ld = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    function automatic bit req_ok(input bit we, input logic [2:0] f3,
                                  input logic [31:0] a);
        case (f3)
            3'd0:    return 1'b1;
            3'd4:    return !we;
            3'd1:    return a[0] == 1'b0;
            3'd5:    return !we && (a[0] == 1'b0);
            3'd2:    return a[1:0] == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3,
                                          input logic [31:0] a);
        int m;
        m = ((1 << nbytes(f3)) - 1) << a[1:0];
        return 4'(m);
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f3,
                                           input logic [31:0] w);
        if (nbytes(f3) == 1) return (w & 32'hFF) * 32'h01010101;
        if (nbytes(f3) == 2) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] exp_ext(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] rd);
        logic [31:0] v;
        logic signed [7:0] sb;
        logic signed [15:0] sh;
        logic signed [31:0] s;
        v = rd >> (8 * a[1:0]);
        case (f3)
            3'd0: begin
                sb = v[7:0];
                s = sb;
                return s;
            end
            3'd1: begin
                sh = v[15:0];
                s = sh;
                return s;
            end
            3'd4:    return v & 32'hFF;
            3'd5:    return v & 32'hFFFF;
            default: return v;
        endcase
    endfunction

    task automatic idle_cycle(input bit force_rv);
        req_valid = 1'b0;
        req_we = 1'($urandom_range(0, 1));
        req_func3 = 3'($urandom_range(0, 7));
        req_addr = $urandom;
        req_wdata = $urandom;
        bus.bus_gnt = 1'($urandom_range(0, 1));
        bus.bus_rvalid = force_rv ? 1'b1 : 1'($urandom_range(0, 1));
        bus.bus_rdata = $urandom;
        @(negedge clk);
        chk("idle_stall", stall, 0);
        chk("idle_misalign", misalign, 0);
        chk("idle_bus_req", bus.bus_req, 0);
        chk("idle_ld_valid", ld_valid, 0);
        chk("idle_bus_err", bus_err, 0);
        chk("idle_ld_data", ld_data, exp_ld);
        @(posedge clk);
        #1;
    endtask

    // g: extra ADDR cycles before gnt; r: extra RESP cycles before rvalid.
    task automatic run_txn(input bit we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int g, input int r);
        bit ok;
        bit to;
        int n;
        int last;
        int done;
        int rq;
        bit req_on;
        ok = req_ok(we, f3, a);
        n = g + r + 2;
        to = (n > T);
        last = to ? T : n;
        done = last + 1;
        rq = (g + 1 < T) ? g + 1 : T;
        req_valid = 1'b1;
        req_we = we;
        req_func3 = f3;
        req_addr = a;
        req_wdata = wd;
        bus.bus_rdata = rd;
        if (!ok) begin
            bus.bus_gnt = 1'($urandom_range(0, 1));
            bus.bus_rvalid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("mis_pulse", misalign, 1);
            chk("mis_stall", stall, 0);
            chk("mis_bus_req", bus.bus_req, 0);
            chk("mis_ld_valid", ld_valid, 0);
            chk("mis_ld_data", ld_data, exp_ld);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            @(negedge clk);
            chk("mis_after_req", bus.bus_req, 0);
            chk("mis_after_pulse", misalign, 0);
            @(posedge clk);
            #1;
            return;
        end
        for (int c = 0; c <= done; c++) begin
            if (c == g + 1) bus.bus_gnt = 1'b1;
            else if (c >= 1 && c <= g) bus.bus_gnt = 1'b0;
            else bus.bus_gnt = 1'($urandom_range(0, 1));
            if (c == g + 2 + r) bus.bus_rvalid = 1'b1;
            else if (c >= g + 2 && c < g + 2 + r) bus.bus_rvalid = 1'b0;
            else bus.bus_rvalid = 1'($urandom_range(0, 1));
            @(negedge clk);
            req_on = (c >= 1) && (c <= rq);
            chk("stall", stall, 32'(c <= last));
            chk("misalign", misalign, 0);
            chk("bus_req", bus.bus_req, 32'(req_on));
            if (req_on) begin
                chk("bus_addr", bus.bus_addr, a & 32'hFFFF_FFFC);
                chk("bus_be", bus.bus_be, exp_be(f3, a));
                chk("bus_we", bus.bus_we, 32'(we));
                if (we) chk("bus_wdata", bus.bus_wdata, exp_wd(f3, wd));
            end
            if (c == done) begin
                if (to) exp_ld = 32'h0;
                else if (!we) exp_ld = exp_ext(f3, a, rd);
            end
            chk("ld_valid", ld_valid, 32'(c == done && !to && !we));
            chk("bus_err", bus_err, 32'(c == done && to));
            chk("ld_data", ld_data, exp_ld);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        bus.bus_gnt = 1'b0;
        bus.bus_rvalid = 1'b0;
        bus.bus_rdata = 32'h0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_ld_data", ld_data, 0);
        chk("rst_ld_valid", ld_valid, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_bus_req", bus.bus_req, 0);
        chk("rst_bus_we", bus.bus_we, 0);
        chk("rst_bus_addr", bus.bus_addr, 0);
        chk("rst_bus_be", bus.bus_be, 0);
        chk("rst_bus_wdata", bus.bus_wdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_cycle(1'b0);

        chk("pin_lb", exp_ext(3'd0, 32'h103, 32'h80FF_0000), 32'hFFFF_FF80);
        chk("pin_lbu", exp_ext(3'd4, 32'h103, 32'h80FF_0000), 32'h0000_0080);
        chk("pin_be_sh", exp_be(3'd1, 32'h202), 4'b1100);
        chk("pin_wd_sh", exp_wd(3'd1, 32'h1234_ABCD), 32'hABCD_ABCD);
        chk("pin_be_sb", exp_be(3'd0, 32'h3), 4'b1000);

        run_txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
        chk("lw_lit", ld_data, 32'hDEAD_BEEF);
        run_txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
        chk("lb_lit", ld_data, 32'hFFFF_FF80);
        run_txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
        chk("lbu_lit", ld_data, 32'h0000_0080);
        run_txn(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0);
        chk("sh_keeps_ld", ld_data, 32'h0000_0080);
        run_txn(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 0);
        run_txn(1'b1, 3'd4, 32'h200, 32'h55, 32'h0, 0, 0);
        run_txn(1'b0, 3'd3, 32'h200, 32'h0, 32'h0, 0, 0);
        run_txn(1'b0, 3'd2, 32'h400, 32'h0, 32'hCAFE_F00D, 4, 1);
        chk("slow_lw_lit", ld_data, 32'hCAFE_F00D);
        run_txn(1'b0, 3'd2, 32'h500, 32'h0, 32'h1111_2222, 20, 0);
        chk("to_ld_zero", ld_data, 32'h0);
        run_txn(1'b0, 3'd5, 32'h502, 32'h0, 32'h9876_0000, 0, 6);
        chk("lhu_edge_lit", ld_data, 32'h0000_9876);
        run_txn(1'b1, 3'd2, 32'h600, 32'h0BAD_F00D, 32'h0, 1, 6);

        // Reset landing in RESP, followed by a stale rvalid.
        run_txn(1'b0, 3'd2, 32'h700, 32'h0, 32'h7777_0001, 0, 0);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_func3 = 3'd2;
        req_addr = 32'h800;
        bus.bus_rdata = 32'h1234_5678;
        bus.bus_gnt = 1'b0;
        bus.bus_rvalid = 1'b0;
        @(posedge clk);
        #1;
        bus.bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.bus_gnt = 1'b0;
        @(negedge clk);
        chk("mid_resp_stall", stall, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_bus_req", bus.bus_req, 0);
        chk("mid_rst_ld_data", ld_data, 0);
        chk("mid_rst_ld_valid", ld_valid, 0);
        chk("mid_rst_bus_err", bus_err, 0);
        chk("mid_rst_misalign", misalign, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_ld = 32'h0;
        for (int i = 0; i < 3; i++) idle_cycle(1'b1);

        for (int k = 0; k < 300; k++) begin
            bit we;
            logic [2:0] f3;
            logic [31:0] a;
            int g;
            int r;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
            g = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                                            : $urandom_range(0, 2);
            r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                                            : $urandom_range(0, 2);
            run_txn(we, f3, a, $urandom, $urandom, g, r);
            for (int j = $urandom_range(0, 2); j > 0; j--) idle_cycle(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
